// File: rtl/gearbox_pkg.sv
// Shared constants and parameter-legality helpers for the gearbox FIFO.
// Derived sizes are computed from the instance parameters via these functions.
package gearbox_pkg;

  localparam int DIN_W_DEF = 2;
  localparam int RATIO_DEF = 4;
  localparam int ABITS_DEF = 3;

  function automatic int gb_depth(input int abits);
    return 1 << abits;
  endfunction

  function automatic int gb_words(input int abits, input int ratio);
    return (1 << abits) / ratio;
  endfunction

  function automatic int gb_lvl_w(input int abits);
    return abits + 1;
  endfunction

  function automatic int gb_wa(input int abits, input int ratio);
    int w;
    w = gb_words(abits, ratio);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic bit gb_ratio_ok(input int ratio);
    return (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
  endfunction

  function automatic bit gb_depth_ok(input int abits, input int ratio);
    return (ratio <= (1 << abits)) && (((1 << abits) % ratio) == 0);
  endfunction

endpackage

// File: rtl/gearbox_sym_ram.sv
// Symbol store: one symbol write port, one RATIO-symbol aligned word read port.
// A popped word is cleared so later flush padding reads back as zeros.
module gearbox_sym_ram
  import gearbox_pkg::*;
#(
  parameter int DIN_W = 2,
  parameter int RATIO = 4,
  parameter int ABITS = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              we,
  input  logic [ABITS-1:0]                  waddr,
  input  logic [DIN_W-1:0]                  wdata,
  input  logic                              clr,
  input  logic [gb_wa(ABITS, RATIO)-1:0]    rword,
  output logic [RATIO*DIN_W-1:0]            rdata
);

  localparam int DEPTH = gb_depth(ABITS);
  localparam int RB    = $clog2(RATIO);

  logic [DIN_W-1:0] mem [DEPTH];

  // storage update: clear popped word, then accept the new symbol
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clr) begin
        for (int i = 0; i < RATIO; i++)
          mem[(ABITS'(rword) << RB) | ABITS'(i)] <= '0;
      end
      if (we) mem[waddr] <= wdata;
    end
  end

  // aligned word read, first symbol in the low bits
  always_comb begin
    rdata = '0;
    for (int i = 0; i < RATIO; i++)
      rdata[i*DIN_W +: DIN_W] = mem[(ABITS'(rword) << RB) | ABITS'(i)];
  end

endmodule

// File: rtl/gearbox_fifo.sv
// Width-converting FIFO: DIN_W-bit symbols in, RATIO packed symbols out.
// Optional flush padding and last tags are built when GEARBOX_FLUSH_EN is defined.
module gearbox_fifo
  import gearbox_pkg::*;
#(
  parameter int DIN_W = 2,
  parameter int RATIO = 4,
  parameter int ABITS = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   write,
  input  logic                   read,
  input  logic                   flush,
  input  logic [DIN_W-1:0]       din,
  output logic                   empty,
  output logic                   full,
  output logic                   rd_avail,
  output logic [ABITS:0]         level,
  output logic [RATIO*DIN_W-1:0] dout,
  output logic                   dout_valid,
  output logic                   dout_last
);

  localparam int DEPTH = gb_depth(ABITS);
  localparam int LVL_W = gb_lvl_w(ABITS);
  localparam int WA    = gb_wa(ABITS, RATIO);
  localparam int RB    = $clog2(RATIO);

  if (!gb_ratio_ok(RATIO)) begin : g_bad_ratio
    $error("gearbox_fifo: RATIO must be a power of two >= 2");
  end
  if (!gb_depth_ok(ABITS, RATIO)) begin : g_bad_depth
    $error("gearbox_fifo: 2**ABITS must be a multiple of RATIO");
  end

  logic [ABITS-1:0]       wp, rp, wp_aw, wp_nx;
  logic [LVL_W-1:0]       lvl_aw, lvl_nx, pad;
  logic                   wr_ok, rd_ok, do_pad, last_nx;
  logic [WA-1:0]          rd_w, wp_w;
  logic [RATIO*DIN_W-1:0] rdata;

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));
  assign rd_avail = (level >= LVL_W'(RATIO));
  assign rd_w     = WA'(rp >> RB);
  assign wp_w     = WA'(wp_aw >> RB);

  // accept decisions and next pointer/level, flush applied after the write
  always_comb begin
    wr_ok  = write && !full;
    rd_ok  = read && rd_avail;
    lvl_aw = level + LVL_W'(wr_ok);
    wp_aw  = wp + ABITS'(wr_ok);
    pad    = '0;
    do_pad = 1'b0;
`ifdef GEARBOX_FLUSH_EN
    if (flush && (lvl_aw[RB-1:0] != '0)) begin
      do_pad = 1'b1;
      pad    = LVL_W'(RATIO) - LVL_W'(lvl_aw[RB-1:0]);
    end
`endif
    lvl_nx = lvl_aw + pad - (rd_ok ? LVL_W'(RATIO) : '0);
    wp_nx  = wp_aw + pad[ABITS-1:0];
  end

  // pointer and level registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp_nx;
      level <= lvl_nx;
      if (rd_ok) rp <= rp + ABITS'(RATIO);
    end
  end

`ifdef GEARBOX_FLUSH_EN
  logic [gb_words(ABITS, RATIO)-1:0] tags;

  // per-word last tags: cleared on pop, set on the padded word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tags <= '0;
    end else begin
      if (rd_ok)  tags[rd_w] <= 1'b0;
      if (do_pad) tags[wp_w] <= 1'b1;
    end
  end

  assign last_nx = tags[rd_w];
`else
  logic unused_flush;
  assign unused_flush = flush ^ do_pad ^ (|wp_w);
  assign last_nx      = 1'b0;
`endif

  gearbox_sym_ram #(
    .DIN_W (DIN_W),
    .RATIO (RATIO),
    .ABITS (ABITS)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_ok),
    .waddr   (wp),
    .wdata   (din),
    .clr     (rd_ok),
    .rword   (rd_w),
    .rdata   (rdata)
  );

  // registered output word with one-cycle valid pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      if (rd_ok) begin
        dout      <= rdata;
        dout_last <= last_nx;
      end
    end
  end

endmodule

// File: tb/tb_gearbox_fifo.sv
// Self-checking bench for gearbox_fifo with default parameters.
// Expected words come from a symbol-queue model; checks are inline per task.
module tb_gearbox_fifo;

  logic       clk, reset_n, write, read, flush;
  logic [1:0] din;
  logic       empty, full, rd_avail, dout_valid, dout_last;
  logic [3:0] level;
  logic [7:0] dout;

  int tests = 0;
  int fails = 0;

  logic [1:0] sym_q [$];
  bit         lst_q [$];
  logic [7:0] exp_q [$];
  bit         expl_q [$];

  gearbox_fifo #(.DIN_W(2), .RATIO(4), .ABITS(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .write      (write),
    .read       (read),
    .flush      (flush),
    .din        (din),
    .empty      (empty),
    .full       (full),
    .rd_avail   (rd_avail),
    .level      (level),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of stimulus and advance the reference model
  task automatic drive(input bit w, input bit r, input bit f,
                       input logic [1:0] d, output bit rd);
    int n;
    logic [7:0] wd;
    bit wl;
    n  = sym_q.size();
    rd = r && (n >= 4);
    write = w; read = r; flush = f; din = d;
    if (rd) begin
      wd = '0; wl = 1'b0;
      for (int i = 0; i < 4; i++) begin
        wd[i*2 +: 2] = sym_q.pop_front();
        wl = wl | lst_q.pop_front();
      end
      exp_q.push_back(wd);
      expl_q.push_back(wl);
    end
    if (w && (n < 8)) begin
      sym_q.push_back(d);
      lst_q.push_back(1'b0);
    end
`ifdef GEARBOX_FLUSH_EN
    if (f && (sym_q.size() % 4 != 0)) begin
      while (sym_q.size() % 4 != 0) begin
        sym_q.push_back(2'b00);
        lst_q.push_back(1'b0);
      end
      lst_q[lst_q.size()-1] = 1'b1;
    end
`endif
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; write = 1'b1; read = 1'b1; flush = 1'b1; din = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
    tests++; if (rd_avail !== 1'b0) begin fails++; $display("FAIL reset_rd_avail got %b want 0", rd_avail); end
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout got %h want 00", dout); end
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    tests++; if (dout_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", dout_last); end
    write = 1'b0; read = 1'b0; flush = 1'b0; din = 2'd0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL post_reset_level got %0d want 0", level); end
  endtask

  task automatic test_basic();
    bit rd;
    logic [1:0] syms [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) drive(1, 0, 0, syms[i], rd);
    tests++; if (rd_avail !== 1'b1) begin fails++; $display("FAIL basic_rd_avail got %b want 1", rd_avail); end
    tests++; if (level !== 4'd4) begin fails++; $display("FAIL basic_level got %0d want 4", level); end
    drive(0, 1, 0, 2'd0, rd);
    tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", dout_valid); end
    if (exp_q.size() != 0) begin
      tests++; if (dout !== exp_q.pop_front()) begin fails++; $display("FAIL basic_dout got %h want model", dout); end
      void'(expl_q.pop_front());
    end
    tests++; if (dout !== 8'h39) begin fails++; $display("FAIL basic_dout_const got %h want 39", dout); end
    tests++; if (dout_last !== 1'b0) begin fails++; $display("FAIL basic_last got %b want 0", dout_last); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL basic_empty got %b want 1", empty); end
    drive(0, 0, 0, 2'd0, rd);
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse got %b want 0", dout_valid); end
    tests++; if (dout !== 8'h39) begin fails++; $display("FAIL basic_hold got %h want 39", dout); end
    drive(0, 1, 0, 2'd0, rd);
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL basic_empty_read got %b want 0", dout_valid); end
  endtask

  task automatic test_full();
    bit rd;
    logic [7:0] e;
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 2'((i * 3 + 1) % 4), rd);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag got %b want 1", full); end
    tests++; if (level !== 4'd8) begin fails++; $display("FAIL full_level got %0d want 8", level); end
    drive(1, 0, 0, 2'd3, rd);
    tests++; if (level !== 4'd8) begin fails++; $display("FAIL full_drop got %0d want 8", level); end
    for (int j = 0; j < 2; j++) begin
      drive(0, 1, 0, 2'd0, rd);
      tests++; if (dout_valid !== rd) begin fails++; $display("FAIL full_valid got %b want %b", dout_valid, rd); end
      if (rd) begin
        e = exp_q.pop_front(); void'(expl_q.pop_front());
        tests++; if (dout !== e) begin fails++; $display("FAIL full_word got %h want %h", dout, e); end
      end
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_simul();
    bit rd;
    logic [7:0] e;
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 2'(i), rd);
    drive(1, 1, 0, 2'd2, rd);
    tests++; if (level !== 4'd1) begin fails++; $display("FAIL simul_lvl1 got %0d want 1", level); end
    if (rd) begin
      e = exp_q.pop_front(); void'(expl_q.pop_front());
      tests++; if (dout !== e) begin fails++; $display("FAIL simul_word1 got %h want %h", dout, e); end
    end
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 2'(3 - (i % 4)), rd);
    tests++; if (level !== 4'd8) begin fails++; $display("FAIL simul_lvl8 got %0d want 8", level); end
    drive(1, 1, 0, 2'd1, rd);
    tests++; if (level !== 4'd4) begin fails++; $display("FAIL simul_lvl4 got %0d want 4", level); end
    if (rd) begin
      e = exp_q.pop_front(); void'(expl_q.pop_front());
      tests++; if (dout !== e) begin fails++; $display("FAIL simul_word2 got %h want %h", dout, e); end
    end
    drive(0, 1, 0, 2'd0, rd);
    if (rd) begin
      e = exp_q.pop_front(); void'(expl_q.pop_front());
      tests++; if (dout !== e) begin fails++; $display("FAIL simul_word3 got %h want %h", dout, e); end
    end
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL simul_lvl0 got %0d want 0", level); end
  endtask

  task automatic test_flush();
    bit rd;
    logic [7:0] e;
    bit el;
    drive(0, 0, 1, 2'd0, rd);
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL flush_noop got %0d want 0", level); end
    drive(1, 0, 0, 2'd3, rd);
    drive(1, 0, 0, 2'd1, rd);
    drive(0, 0, 1, 2'd0, rd);
`ifdef GEARBOX_FLUSH_EN
    tests++; if (level !== 4'd4) begin fails++; $display("FAIL flush_level got %0d want 4", level); end
    tests++; if (rd_avail !== 1'b1) begin fails++; $display("FAIL flush_rd_avail got %b want 1", rd_avail); end
`else
    tests++; if (level !== 4'd2) begin fails++; $display("FAIL flush_level got %0d want 2", level); end
    drive(1, 0, 0, 2'd0, rd);
    drive(1, 0, 0, 2'd0, rd);
`endif
    drive(0, 1, 0, 2'd0, rd);
    tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL flush_valid got %b want 1", dout_valid); end
    if (rd) begin
      e = exp_q.pop_front(); el = expl_q.pop_front();
      tests++; if (dout !== e) begin fails++; $display("FAIL flush_dout got %h want %h", dout, e); end
      tests++; if (dout_last !== el) begin fails++; $display("FAIL flush_last got %b want %b", dout_last, el); end
    end
    tests++; if (dout !== 8'h07) begin fails++; $display("FAIL flush_dout_const got %h want 07", dout); end
`ifdef GEARBOX_FLUSH_EN
    drive(1, 0, 0, 2'd2, rd);
    drive(1, 0, 1, 2'd2, rd);
    drive(0, 1, 0, 2'd0, rd);
    if (rd) begin
      e = exp_q.pop_front(); el = expl_q.pop_front();
      tests++; if (dout_last !== el) begin fails++; $display("FAIL flush2_last got %b want %b", dout_last, el); end
      tests++; if (dout !== e) begin fails++; $display("FAIL flush2_dout got %h want %h", dout, e); end
    end
`endif
  endtask

  task automatic test_wrap();
    bit rd, r;
    logic [7:0] e;
    bit el;
    for (int i = 0; i < 20; i++) begin
      r = ($urandom_range(0, 2) != 0);
      drive(1, r, 0, 2'($urandom_range(0, 3)), rd);
      tests++; if (dout_valid !== rd) begin fails++; $display("FAIL wrap_valid[%0d] got %b want %b", i, dout_valid, rd); end
      if (rd) begin
        e = exp_q.pop_front(); el = expl_q.pop_front();
        tests++; if (dout !== e) begin fails++; $display("FAIL wrap_word[%0d] got %h want %h", i, dout, e); end
        tests++; if (dout_last !== el) begin fails++; $display("FAIL wrap_last[%0d] got %b want %b", i, dout_last, el); end
      end
      tests++; if (level !== 4'(sym_q.size())) begin fails++; $display("FAIL wrap_level[%0d] got %0d want %0d", i, level, sym_q.size()); end
    end
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 2'(i), rd);
    drive(1, 1, 0, 2'd3, rd);
    if (rd) begin
      void'(exp_q.pop_front()); void'(expl_q.pop_front());
    end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL midreset_level got %0d want 0", level); end
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL midreset_dout got %h want 00", dout); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL midreset_empty got %b want 1", empty); end
    sym_q.delete(); lst_q.delete(); exp_q.delete(); expl_q.delete();
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 0, 0, 2'd1, rd);
    tests++; if (level !== 4'd1) begin fails++; $display("FAIL postreset_write got %0d want 1", level); end
  endtask

  initial begin
    write = 1'b0; read = 1'b0; flush = 1'b0; din = 2'd0; reset_n = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_simul();
    test_flush();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
